// File: rtl/em4100_pkg.sv
// em4100_pkg: shared widths and the scheduler state encoding for the
// EM4100 tag-emulation sequencer.
package em4100_pkg;

    localparam int ID_W       = 40;
    localparam int FRAME_BITS = 64;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        SEND = 2'd2,
        GAP  = 2'd3
    } em4100_sched_state_t;

endpackage

// File: rtl/em4100_rr_pick.sv
// em4100_rr_pick: combinational round-robin finder. Returns the first valid
// slot strictly after rr_ptr_i, wrapping NUM_SLOTS-1 back to 0. The slot at
// rr_ptr_i itself is considered last, so a lone valid slot is always found.
module em4100_rr_pick #(
    parameter  int NUM_SLOTS = 4,
    localparam int SW        = $clog2(NUM_SLOTS)
) (
    input  logic [NUM_SLOTS-1:0] valid_i,
    input  logic [SW-1:0]        rr_ptr_i,
    output logic [SW-1:0]        pick_o,
    output logic                 any_valid_o
);

    // Scan from the farthest candidate to the nearest so the nearest valid slot wins.
    always_comb begin
        logic [SW-1:0] idx;
        idx         = '0;
        pick_o      = '0;
        any_valid_o = |valid_i;
        for (int i = NUM_SLOTS; i >= 1; i--) begin
            idx = SW'((int'(rr_ptr_i) + i) % NUM_SLOTS);
            if (valid_i[idx]) begin
                pick_o = idx;
            end
        end
    end

endmodule

// File: rtl/em4100_id_scheduler.sv
// em4100_id_scheduler: holds a bank of 40-bit tag IDs and feeds one EM4100
// encoder, round-robining over valid slots. Each selected ID is sent as
// REPEAT back-to-back frames followed by GAP_CYCLES of silence.
// Optional feature macro: EM4100_ONESHOT_EN adds a one-shot request port
// (os_req_i/os_data_i/os_ack_o) that takes priority at each LOAD decision.
module em4100_id_scheduler
    import em4100_pkg::*;
#(
    parameter  int NUM_SLOTS    = 4,
    parameter  int FRAME_CYCLES = 128,
    parameter  int REPEAT       = 3,
    parameter  int GAP_CYCLES   = 16,
    localparam int SW           = $clog2(NUM_SLOTS)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            enable_i,
    input  logic            wr_en_i,
    input  logic [SW-1:0]   wr_addr_i,
    input  logic [ID_W-1:0] wr_data_i,
    input  logic            wr_valid_i,
`ifdef EM4100_ONESHOT_EN
    input  logic            os_req_i,
    input  logic [ID_W-1:0] os_data_i,
    output logic            os_ack_o,
`endif
    output logic [ID_W-1:0] enc_data_o,
    output logic            enc_tx_o,
    output logic [SW-1:0]   cur_slot_o,
    output logic            busy_o,
    output logic            frame_done_o
);

    localparam int CNT_MAX = (FRAME_CYCLES > GAP_CYCLES) ? FRAME_CYCLES : GAP_CYCLES;
    localparam int CNT_W   = $clog2(CNT_MAX);
    localparam int REP_W   = (REPEAT > 1) ? $clog2(REPEAT) : 1;

    em4100_sched_state_t   state_q;
    logic [CNT_W-1:0]      cnt_q;
    logic [REP_W-1:0]      rep_q;
    logic [SW-1:0]         rr_ptr_q;
    logic [SW-1:0]         cur_slot_q;
    logic [ID_W-1:0]       enc_data_q;
    logic                  enc_tx_q;
    logic                  busy_q;
    logic                  frame_done_q;

    logic [ID_W-1:0]       slot_id_q [NUM_SLOTS];
    logic [NUM_SLOTS-1:0]  slot_vld_q;

    logic [SW-1:0]         pick;
    logic                  any_valid;
    logic                  start_ok;

`ifdef EM4100_ONESHOT_EN
    logic                  os_ack_q;
    assign start_ok = os_req_i || (enable_i && any_valid);
    assign os_ack_o = os_ack_q;
`else
    assign start_ok = enable_i && any_valid;
`endif

    em4100_rr_pick #(
        .NUM_SLOTS (NUM_SLOTS)
    ) u_rr_pick (
        .valid_i     (slot_vld_q),
        .rr_ptr_i    (rr_ptr_q),
        .pick_o      (pick),
        .any_valid_o (any_valid)
    );

    // Slot storage: host writes land on the clock edge, independent of the FSM.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            slot_vld_q <= '0;
            for (int i = 0; i < NUM_SLOTS; i++) begin
                slot_id_q[i] <= '0;
            end
        end else if (wr_en_i && (int'(wr_addr_i) < NUM_SLOTS)) begin
            slot_vld_q[wr_addr_i] <= wr_valid_i;
            slot_id_q[wr_addr_i]  <= wr_data_i;
        end
    end

    // Scheduler FSM with registered encoder-facing outputs; frame_done is
    // produced one cycle early so it is high exactly on the last frame cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            cnt_q        <= '0;
            rep_q        <= '0;
            rr_ptr_q     <= SW'(NUM_SLOTS - 1);
            cur_slot_q   <= '0;
            enc_data_q   <= '0;
            enc_tx_q     <= 1'b0;
            busy_q       <= 1'b0;
            frame_done_q <= 1'b0;
`ifdef EM4100_ONESHOT_EN
            os_ack_q     <= 1'b0;
`endif
        end else begin
            frame_done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (start_ok) begin
                        state_q <= LOAD;
                        busy_q  <= 1'b1;
`ifdef EM4100_ONESHOT_EN
                        os_ack_q <= os_req_i;
`endif
                    end
                end
                LOAD: begin
`ifdef EM4100_ONESHOT_EN
                    os_ack_q <= 1'b0;
                    if (os_ack_q) begin
                        enc_data_q <= os_data_i;
                        state_q    <= SEND;
                        enc_tx_q   <= 1'b1;
                        cnt_q      <= '0;
                        rep_q      <= '0;
                    end else
`endif
                    if (any_valid) begin
                        rr_ptr_q   <= pick;
                        cur_slot_q <= pick;
                        enc_data_q <= slot_id_q[pick];
                        state_q    <= SEND;
                        enc_tx_q   <= 1'b1;
                        cnt_q      <= '0;
                        rep_q      <= '0;
                    end else begin
                        state_q <= IDLE;
                        busy_q  <= 1'b0;
                    end
                end
                SEND: begin
                    if (cnt_q == CNT_W'(FRAME_CYCLES - 1)) begin
                        cnt_q <= '0;
                        if ((rep_q == REP_W'(REPEAT - 1)) || !enable_i) begin
                            state_q  <= GAP;
                            enc_tx_q <= 1'b0;
                        end else begin
                            rep_q <= rep_q + 1'b1;
                        end
                    end else begin
                        cnt_q        <= cnt_q + 1'b1;
                        frame_done_q <= (cnt_q == CNT_W'(FRAME_CYCLES - 2));
                    end
                end
                GAP: begin
                    if (cnt_q == CNT_W'(GAP_CYCLES - 1)) begin
                        cnt_q <= '0;
                        if (start_ok) begin
                            state_q <= LOAD;
`ifdef EM4100_ONESHOT_EN
                            os_ack_q <= os_req_i;
`endif
                        end else begin
                            state_q <= IDLE;
                            busy_q  <= 1'b0;
                        end
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                default: begin
                    state_q  <= IDLE;
                    enc_tx_q <= 1'b0;
                    busy_q   <= 1'b0;
                end
            endcase
        end
    end

    assign enc_data_o   = enc_data_q;
    assign enc_tx_o     = enc_tx_q;
    assign cur_slot_o   = cur_slot_q;
    assign busy_o       = busy_q;
    assign frame_done_o = frame_done_q;

endmodule

// File: tb/tb_em4100_id_scheduler.sv
// tb_em4100_id_scheduler: directed self-checking bench for the EM4100 ID
// scheduler with default parameters (4 slots, 128-cycle frames, 3 repeats,
// 16-cycle gap). Inputs change and outputs are sampled on the falling edge.
module tb_em4100_id_scheduler;

    logic        clk = 1'b0;
    logic        rst;
    logic        enable;
    logic        wrEn;
    logic [1:0]  wrAddr;
    logic [39:0] wrData;
    logic        wrValid;
    logic [39:0] encData;
    logic        encTx;
    logic [1:0]  curSlot;
    logic        busy;
    logic        frameDone;
`ifdef EM4100_ONESHOT_EN
    logic        osReq;
    logic [39:0] osData;
    logic        osAck;
`endif

    int checkCount = 0;
    int errorCount = 0;

    em4100_id_scheduler dut (
        .clk          (clk),
        .rst          (rst),
        .enable_i     (enable),
        .wr_en_i      (wrEn),
        .wr_addr_i    (wrAddr),
        .wr_data_i    (wrData),
        .wr_valid_i   (wrValid),
`ifdef EM4100_ONESHOT_EN
        .os_req_i     (osReq),
        .os_data_i    (osData),
        .os_ack_o     (osAck),
`endif
        .enc_data_o   (encData),
        .enc_tx_o     (encTx),
        .cur_slot_o   (curSlot),
        .busy_o       (busy),
        .frame_done_o (frameDone)
    );

    // 10 time-unit clock.
    always #5 clk = ~clk;

    // Hard stop in case a bounded wait is ever miscoded.
    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: simulation still running, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    // Pulse reset and return on a falling edge with all inputs idle.
    task automatic doReset();
        rst     = 1'b1;
        enable  = 1'b0;
        wrEn    = 1'b0;
        wrAddr  = '0;
        wrData  = '0;
        wrValid = 1'b0;
`ifdef EM4100_ONESHOT_EN
        osReq   = 1'b0;
        osData  = '0;
`endif
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
    endtask

    // One-cycle slot write strobe.
    task automatic writeSlot(input logic [1:0] addr, input logic [39:0] data, input logic vld);
        wrEn    = 1'b1;
        wrAddr  = addr;
        wrData  = data;
        wrValid = vld;
        @(negedge clk);
        wrEn    = 1'b0;
    endtask

    // Advance falling edges until enc_tx reaches the given level or the limit expires.
    task automatic waitTx(input logic level, input int limit);
        for (int n = 0; n < limit && encTx !== level; n++) begin
            @(negedge clk);
        end
    endtask

    task automatic test_reset();
        rst     = 1'b1;
        enable  = 1'b0;
        wrEn    = 1'b0;
        wrAddr  = '0;
        wrData  = '0;
        wrValid = 1'b0;
`ifdef EM4100_ONESHOT_EN
        osReq   = 1'b0;
        osData  = '0;
`endif
        #1;
        checkCount++;
        if (encTx !== 1'b0) begin errorCount++; $display("[TB] FAIL reset_tx: got %b expected 0", encTx); end
        checkCount++;
        if (encData !== 40'h0) begin errorCount++; $display("[TB] FAIL reset_data: got %h expected 0", encData); end
        checkCount++;
        if (curSlot !== 2'd0) begin errorCount++; $display("[TB] FAIL reset_slot: got %0d expected 0", curSlot); end
        checkCount++;
        if (busy !== 1'b0 || frameDone !== 1'b0) begin
            errorCount++;
            $display("[TB] FAIL reset_busy_fd: got busy=%b fd=%b expected 0/0", busy, frameDone);
        end
        @(negedge clk);
        @(negedge clk);
        rst    = 1'b0;
        enable = 1'b1;
        repeat (3) @(negedge clk);
        checkCount++;
        if (busy !== 1'b0) begin errorCount++; $display("[TB] FAIL reset_no_slots_idle: busy=%b expected 0", busy); end
        enable = 1'b0;
    endtask

    task automatic test_single_slot();
        int txLow;
        int fdCount;
        int fdBad;
        int gapBad;
        doReset();
        writeSlot(2'd0, 40'hBEDEADBEEF, 1'b1);
        enable = 1'b1;
        @(negedge clk);
        checkCount++;
        if (busy !== 1'b1 || encTx !== 1'b0) begin
            errorCount++;
            $display("[TB] FAIL single_load: busy=%b tx=%b expected busy=1 tx=0", busy, encTx);
        end
        @(negedge clk);
        checkCount++;
        if (encTx !== 1'b1) begin errorCount++; $display("[TB] FAIL single_tx_start: got %b expected 1", encTx); end
        checkCount++;
        if (encData !== 40'hBEDEADBEEF) begin errorCount++; $display("[TB] FAIL single_data: got %h expected bedeadbeef", encData); end
        txLow   = 0;
        fdCount = 0;
        fdBad   = 0;
        for (int i = 0; i < 384; i++) begin
            if (encTx !== 1'b1) txLow++;
            if (frameDone === 1'b1) begin
                fdCount++;
                if (i != 127 && i != 255 && i != 383) fdBad++;
            end
            @(negedge clk);
        end
        checkCount++;
        if (txLow != 0) begin errorCount++; $display("[TB] FAIL single_tx_hold: %0d low cycles expected 0", txLow); end
        checkCount++;
        if (fdCount != 3) begin errorCount++; $display("[TB] FAIL single_fd_count: got %0d expected 3", fdCount); end
        checkCount++;
        if (fdBad != 0) begin errorCount++; $display("[TB] FAIL single_fd_pos: %0d misplaced pulses expected 0", fdBad); end
        gapBad = 0;
        for (int i = 0; i < 16; i++) begin
            if (encTx !== 1'b0 || busy !== 1'b1 || frameDone !== 1'b0) gapBad++;
            @(negedge clk);
        end
        checkCount++;
        if (gapBad != 0) begin errorCount++; $display("[TB] FAIL single_gap: %0d bad gap cycles expected 0", gapBad); end
        checkCount++;
        if (encTx !== 1'b0 || busy !== 1'b1) begin
            errorCount++;
            $display("[TB] FAIL single_reload: tx=%b busy=%b expected tx=0 busy=1", encTx, busy);
        end
        @(negedge clk);
        checkCount++;
        if (encTx !== 1'b1 || curSlot !== 2'd0) begin
            errorCount++;
            $display("[TB] FAIL single_period: tx=%b slot=%0d expected tx=1 slot=0", encTx, curSlot);
        end
        enable = 1'b0;
    endtask

    task automatic test_round_robin();
        logic [1:0]  expSlot [4];
        logic [39:0] expData [4];
        int len;
        expSlot = '{2'd0, 2'd1, 2'd3, 2'd0};
        expData = '{40'h1111111111, 40'h2222222222, 40'h4444444444, 40'h1111111111};
        doReset();
        writeSlot(2'd0, 40'h1111111111, 1'b1);
        writeSlot(2'd1, 40'h2222222222, 1'b1);
        writeSlot(2'd2, 40'h3333333333, 1'b0);
        writeSlot(2'd3, 40'h4444444444, 1'b1);
        enable = 1'b1;
        for (int b = 0; b < 4; b++) begin
            waitTx(1'b1, 1000);
            checkCount++;
            if (encTx !== 1'b1) begin errorCount++; $display("[TB] FAIL rr_start%0d: tx=%b expected 1", b, encTx); end
            checkCount++;
            if (curSlot !== expSlot[b]) begin errorCount++; $display("[TB] FAIL rr_slot%0d: got %0d expected %0d", b, curSlot, expSlot[b]); end
            checkCount++;
            if (encData !== expData[b]) begin errorCount++; $display("[TB] FAIL rr_data%0d: got %h expected %h", b, encData, expData[b]); end
            len = 0;
            while (encTx === 1'b1 && len < 1000) begin
                len++;
                @(negedge clk);
            end
            checkCount++;
            if (len != 384) begin errorCount++; $display("[TB] FAIL rr_len%0d: got %0d expected 384", b, len); end
        end
        enable = 1'b0;
    endtask

    task automatic test_enable_drop();
        int len;
        int fd;
        int gapBad;
        doReset();
        writeSlot(2'd0, 40'hBEDEADBEEF, 1'b1);
        enable = 1'b1;
        waitTx(1'b1, 100);
        checkCount++;
        if (encTx !== 1'b1) begin errorCount++; $display("[TB] FAIL drop_start: tx=%b expected 1", encTx); end
        len = 0;
        fd  = 0;
        while (encTx === 1'b1 && len < 1000) begin
            if (len == 168) enable = 1'b0;
            if (frameDone === 1'b1) fd++;
            len++;
            @(negedge clk);
        end
        checkCount++;
        if (len != 256) begin errorCount++; $display("[TB] FAIL drop_len: got %0d expected 256", len); end
        checkCount++;
        if (fd != 2) begin errorCount++; $display("[TB] FAIL drop_fd: got %0d expected 2", fd); end
        gapBad = 0;
        for (int i = 0; i < 16; i++) begin
            if (encTx !== 1'b0 || busy !== 1'b1) gapBad++;
            @(negedge clk);
        end
        checkCount++;
        if (gapBad != 0) begin errorCount++; $display("[TB] FAIL drop_gap: %0d bad gap cycles expected 0", gapBad); end
        checkCount++;
        if (busy !== 1'b0) begin errorCount++; $display("[TB] FAIL drop_idle: busy=%b expected 0", busy); end
        repeat (5) @(negedge clk);
        checkCount++;
        if (busy !== 1'b0 || encTx !== 1'b0) begin
            errorCount++;
            $display("[TB] FAIL drop_stay_idle: busy=%b tx=%b expected 0/0", busy, encTx);
        end
    endtask

    task automatic test_rewrite_active();
        int dataBad;
        int len;
        doReset();
        writeSlot(2'd0, 40'hCAFEF00D01, 1'b1);
        writeSlot(2'd1, 40'h5555555555, 1'b1);
        enable = 1'b1;
        waitTx(1'b1, 100);
        checkCount++;
        if (curSlot !== 2'd0 || encData !== 40'hCAFEF00D01) begin
            errorCount++;
            $display("[TB] FAIL rewrite_first: slot=%0d data=%h expected 0/cafef00d01", curSlot, encData);
        end
        repeat (50) @(negedge clk);
        writeSlot(2'd0, 40'h0123456789, 1'b1);
        dataBad = 0;
        len     = 0;
        while (encTx === 1'b1 && len < 1000) begin
            if (encData !== 40'hCAFEF00D01) dataBad++;
            len++;
            @(negedge clk);
        end
        checkCount++;
        if (dataBad != 0) begin errorCount++; $display("[TB] FAIL rewrite_hold: %0d changed cycles expected 0", dataBad); end
        waitTx(1'b1, 100);
        checkCount++;
        if (curSlot !== 2'd1 || encData !== 40'h5555555555) begin
            errorCount++;
            $display("[TB] FAIL rewrite_second: slot=%0d data=%h expected 1/5555555555", curSlot, encData);
        end
        waitTx(1'b0, 1000);
        waitTx(1'b1, 100);
        checkCount++;
        if (curSlot !== 2'd0 || encData !== 40'h0123456789) begin
            errorCount++;
            $display("[TB] FAIL rewrite_new: slot=%0d data=%h expected 0/0123456789", curSlot, encData);
        end
        enable = 1'b0;
    endtask

    task automatic test_reset_mid_frame();
        int bad;
        doReset();
        writeSlot(2'd0, 40'hBEDEADBEEF, 1'b1);
        enable = 1'b1;
        waitTx(1'b1, 100);
        repeat (50) @(negedge clk);
        checkCount++;
        if (encTx !== 1'b1) begin errorCount++; $display("[TB] FAIL rstmid_pre: tx=%b expected 1", encTx); end
        rst = 1'b1;
        #1;
        checkCount++;
        if (encTx !== 1'b0 || busy !== 1'b0) begin
            errorCount++;
            $display("[TB] FAIL rstmid_async: tx=%b busy=%b expected 0/0", encTx, busy);
        end
        checkCount++;
        if (encData !== 40'h0 || curSlot !== 2'd0 || frameDone !== 1'b0) begin
            errorCount++;
            $display("[TB] FAIL rstmid_outputs: data=%h slot=%0d fd=%b expected 0/0/0", encData, curSlot, frameDone);
        end
        @(negedge clk);
        rst = 1'b0;
        bad = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (busy !== 1'b0 || encTx !== 1'b0) bad++;
        end
        checkCount++;
        if (bad != 0) begin errorCount++; $display("[TB] FAIL rstmid_slots_cleared: %0d busy cycles expected 0", bad); end
        enable = 1'b0;
    endtask

`ifdef EM4100_ONESHOT_EN
    task automatic test_oneshot();
        int len;
        int extraAck;
        doReset();
        writeSlot(2'd0, 40'h1111111111, 1'b1);
        writeSlot(2'd1, 40'h2222222222, 1'b1);
        writeSlot(2'd2, 40'h3333333333, 1'b1);
        enable = 1'b1;
        waitTx(1'b1, 100);
        waitTx(1'b0, 1000);
        waitTx(1'b1, 100);
        checkCount++;
        if (curSlot !== 2'd1) begin errorCount++; $display("[TB] FAIL os_pre_slot: got %0d expected 1", curSlot); end
        osData = 40'hABCDE12345;
        osReq  = 1'b1;
        for (int n = 0; n < 2000 && osAck !== 1'b1; n++) @(negedge clk);
        checkCount++;
        if (osAck !== 1'b1 || encTx !== 1'b0) begin
            errorCount++;
            $display("[TB] FAIL os_ack: ack=%b tx=%b expected 1/0", osAck, encTx);
        end
        osReq = 1'b0;
        @(negedge clk);
        checkCount++;
        if (encTx !== 1'b1 || encData !== 40'hABCDE12345 || curSlot !== 2'd1) begin
            errorCount++;
            $display("[TB] FAIL os_send: tx=%b data=%h slot=%0d expected 1/abcde12345/1", encTx, encData, curSlot);
        end
        len      = 0;
        extraAck = 0;
        while (encTx === 1'b1 && len < 1000) begin
            if (osAck === 1'b1) extraAck++;
            len++;
            @(negedge clk);
        end
        checkCount++;
        if (len != 384 || extraAck != 0) begin
            errorCount++;
            $display("[TB] FAIL os_burst: len=%0d acks=%0d expected 384/0", len, extraAck);
        end
        waitTx(1'b1, 100);
        checkCount++;
        if (curSlot !== 2'd2 || encData !== 40'h3333333333) begin
            errorCount++;
            $display("[TB] FAIL os_next_rr: slot=%0d data=%h expected 2/3333333333", curSlot, encData);
        end
        osData = '0;
        enable = 1'b0;
    endtask
`endif

    // Run every scenario in order, then report the totals.
    initial begin
        test_reset();
        test_single_slot();
        test_round_robin();
        test_enable_drop();
        test_rewrite_active();
        test_reset_mid_frame();
`ifdef EM4100_ONESHOT_EN
        test_oneshot();
`endif
        $display("CHECKS %0d ERRORS %0d", checkCount, errorCount);
        $finish;
    end

endmodule
